// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arb_pkg;

  localparam int unsigned MEM_ARB_PORTS = 2;
  localparam int unsigned MEM_DATA_W    = 8;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } mem_arb_state_t;

endpackage

// File: rtl/rr_picker.sv
// Combinational 2-way grant. MEM_ARB_RR_EN selects round-robin via ptr,
// otherwise port 0 wins every simultaneous request.
module rr_picker
  import mem_arb_pkg::*;
(
  input  logic [MEM_ARB_PORTS-1:0] req,
`ifdef MEM_ARB_RR_EN
  input  logic                     ptr,
`endif
  output logic                     gnt_valid_c,
  output logic                     gnt_idx_c
);

  always_comb begin
    gnt_valid_c = |req;
    gnt_idx_c   = 1'b0;
    if (req == 2'b11) begin
`ifdef MEM_ARB_RR_EN
      gnt_idx_c = ptr;
`else
      gnt_idx_c = 1'b0;
`endif
    end else begin
      gnt_idx_c = req[1];
    end
  end

endmodule

// File: rtl/memory_arbiter.sv
// Two-port arbiter/sequencer for the shared memory array (IDLE/ACCESS/DONE).
// Build option: MEM_ARB_RR_EN enables round-robin arbitration.
module memory_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned N = 2
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  Req0,
  input  logic                  Req1,
  input  logic                  Wr_en0,
  input  logic                  Wr_en1,
  input  logic [N-1:0]          Addr0,
  input  logic [N-1:0]          Addr1,
  input  logic [MEM_DATA_W-1:0] Wdata0,
  input  logic [MEM_DATA_W-1:0] Wdata1,
  output logic                  Ack0,
  output logic                  Ack1,
  output logic [MEM_DATA_W-1:0] Rdata0,
  output logic [MEM_DATA_W-1:0] Rdata1,
  output logic [N-1:0]          Mem_addr,
  output logic [MEM_DATA_W-1:0] Mem_data_in,
  output logic                  Mem_wr,
  output logic                  Mem_rd,
  input  logic [MEM_DATA_W-1:0] Mem_data_out
);

  mem_arb_state_t               state_q, state_d;
  logic                         port_q, port_d;
  logic                         wr_q, wr_d;
  logic [N-1:0]                 mem_addr_q, mem_addr_d;
  logic [MEM_DATA_W-1:0]        mem_data_in_q, mem_data_in_d;
  logic                         mem_wr_q, mem_wr_d;
  logic                         mem_rd_q, mem_rd_d;
  logic [MEM_ARB_PORTS-1:0]     ack_q, ack_d;
  logic [MEM_DATA_W-1:0]        rdata0_q, rdata0_d;
  logic [MEM_DATA_W-1:0]        rdata1_q, rdata1_d;
  logic                         gnt_valid_c;
  logic                         gnt_idx_c;

`ifdef MEM_ARB_RR_EN
  logic                         ptr_q, ptr_d;
`endif

  rr_picker u_picker (
    .req         ({Req1, Req0}),
`ifdef MEM_ARB_RR_EN
    .ptr         (ptr_q),
`endif
    .gnt_valid_c (gnt_valid_c),
    .gnt_idx_c   (gnt_idx_c)
  );

  // Next-state and registered-output logic
  always_comb begin
    state_d       = state_q;
    port_d        = port_q;
    wr_d          = wr_q;
    mem_addr_d    = mem_addr_q;
    mem_data_in_d = mem_data_in_q;
    mem_wr_d      = 1'b0;
    mem_rd_d      = 1'b0;
    ack_d         = '0;
    rdata0_d      = rdata0_q;
    rdata1_d      = rdata1_q;
`ifdef MEM_ARB_RR_EN
    ptr_d         = ptr_q;
`endif
    case (state_q)
      IDLE: begin
        if (gnt_valid_c) begin
          state_d       = ACCESS;
          port_d        = gnt_idx_c;
          wr_d          = gnt_idx_c ? Wr_en1 : Wr_en0;
          mem_addr_d    = gnt_idx_c ? Addr1  : Addr0;
          mem_data_in_d = gnt_idx_c ? Wdata1 : Wdata0;
          mem_wr_d      = gnt_idx_c ? Wr_en1  : Wr_en0;
          mem_rd_d      = gnt_idx_c ? ~Wr_en1 : ~Wr_en0;
`ifdef MEM_ARB_RR_EN
          ptr_d         = ~gnt_idx_c;
`endif
        end
      end
      ACCESS: begin
        state_d       = DONE;
        ack_d[port_q] = 1'b1;
        // Read data is only ever steered into the port that owns the read
        if (!wr_q) begin
          if (port_q) rdata1_d = Mem_data_out;
          else        rdata0_d = Mem_data_out;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q       <= IDLE;
      port_q        <= 1'b0;
      wr_q          <= 1'b0;
      mem_addr_q    <= '0;
      mem_data_in_q <= '0;
      mem_wr_q      <= 1'b0;
      mem_rd_q      <= 1'b0;
      ack_q         <= '0;
      rdata0_q      <= '0;
      rdata1_q      <= '0;
`ifdef MEM_ARB_RR_EN
      ptr_q         <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      port_q        <= port_d;
      wr_q          <= wr_d;
      mem_addr_q    <= mem_addr_d;
      mem_data_in_q <= mem_data_in_d;
      mem_wr_q      <= mem_wr_d;
      mem_rd_q      <= mem_rd_d;
      ack_q         <= ack_d;
      rdata0_q      <= rdata0_d;
      rdata1_q      <= rdata1_d;
`ifdef MEM_ARB_RR_EN
      ptr_q         <= ptr_d;
`endif
    end
  end

  assign Ack0        = ack_q[0];
  assign Ack1        = ack_q[1];
  assign Rdata0      = rdata0_q;
  assign Rdata1      = rdata1_q;
  assign Mem_addr    = mem_addr_q;
  assign Mem_data_in = mem_data_in_q;
  assign Mem_wr      = mem_wr_q;
  assign Mem_rd      = mem_rd_q;

endmodule

// File: tb/tb_memory_arbiter.sv
// Self-checking bench for memory_arbiter: transaction-level model plus directed and random stimulus.
module tb_memory_arbiter;

  localparam int N = 2;

  logic         Clk = 1'b0;
  logic         Rst = 1'b1;
  logic         Req0 = 1'b0, Req1 = 1'b0;
  logic         Wr_en0 = 1'b0, Wr_en1 = 1'b0;
  logic [N-1:0] Addr0 = '0, Addr1 = '0;
  logic [7:0]   Wdata0 = '0, Wdata1 = '0;
  logic         Ack0, Ack1;
  logic [7:0]   Rdata0, Rdata1;
  logic [N-1:0] Mem_addr;
  logic [7:0]   Mem_data_in;
  logic         Mem_wr, Mem_rd;
  logic [7:0]   Mem_data_out;

  int n_checks = 0;
  int n_err    = 0;
  bit chk_en   = 1'b0;

  always #5 Clk = ~Clk;

  memory_arbiter #(.N(N)) dut (
    .Clk(Clk), .Rst(Rst),
    .Req0(Req0), .Req1(Req1), .Wr_en0(Wr_en0), .Wr_en1(Wr_en1),
    .Addr0(Addr0), .Addr1(Addr1), .Wdata0(Wdata0), .Wdata1(Wdata1),
    .Ack0(Ack0), .Ack1(Ack1), .Rdata0(Rdata0), .Rdata1(Rdata1),
    .Mem_addr(Mem_addr), .Mem_data_in(Mem_data_in),
    .Mem_wr(Mem_wr), .Mem_rd(Mem_rd), .Mem_data_out(Mem_data_out)
  );

  // Memory array seen by the DUT
  logic [7:0] mem_env [4];
  assign Mem_data_out = mem_env[Mem_addr];
  always @(posedge Clk) if (Mem_wr === 1'b1) mem_env[Mem_addr] <= Mem_data_in;

  // Reference model: one transaction in flight, stepped through access/done phases
  logic [7:0]   mem_ref [4];
  int           phase = 0;
  bit           ptr = 1'b0;
  bit           win, m_wr;
  logic [N-1:0] m_addr;
  logic [7:0]   m_wdata;
  bit           e_ack0, e_ack1, e_wr, e_rd;
  logic [N-1:0] e_addr;
  logic [7:0]   e_din, e_rd0, e_rd1;

  always @(posedge Clk) begin
    if (Rst) begin
      if (phase == 1 && m_wr) mem_ref[m_addr] = m_wdata;
      phase = 0; ptr = 1'b0;
      e_ack0 = 0; e_ack1 = 0; e_wr = 0; e_rd = 0;
      e_addr = '0; e_din = '0; e_rd0 = '0; e_rd1 = '0;
    end else begin
      case (phase)
        0: begin
          e_ack0 = 0; e_ack1 = 0; e_wr = 0; e_rd = 0;
          if (Req0 || Req1) begin
            if (Req0 && Req1) begin
`ifdef MEM_ARB_RR_EN
              win = ptr;
`else
              win = 1'b0;
`endif
            end else begin
              win = Req1;
            end
            ptr     = !win;
            m_wr    = win ? Wr_en1 : Wr_en0;
            m_addr  = win ? Addr1 : Addr0;
            m_wdata = win ? Wdata1 : Wdata0;
            e_addr = m_addr; e_din = m_wdata; e_wr = m_wr; e_rd = !m_wr;
            phase = 1;
          end
        end
        1: begin
          e_wr = 0; e_rd = 0;
          if (win) e_ack1 = 1; else e_ack0 = 1;
          if (m_wr) mem_ref[m_addr] = m_wdata;
          else if (win) e_rd1 = mem_ref[m_addr];
          else e_rd0 = mem_ref[m_addr];
          phase = 2;
        end
        default: begin
          e_ack0 = 0; e_ack1 = 0;
          phase = 0;
        end
      endcase
    end
  end

  // Cycle-by-cycle compare against the model
  always @(negedge Clk) begin
    if (chk_en) begin
      n_checks++;
      if ({Ack0, Ack1, Mem_wr, Mem_rd, Mem_addr, Mem_data_in, Rdata0, Rdata1} !==
          {e_ack0, e_ack1, e_wr, e_rd, e_addr, e_din, e_rd0, e_rd1}) begin
        n_err++;
        $display("FAIL cycle_cmp t=%0t got ack=%b%b wr=%b rd=%b addr=%h din=%h r0=%h r1=%h want ack=%b%b wr=%b rd=%b addr=%h din=%h r0=%h r1=%h",
                 $time, Ack0, Ack1, Mem_wr, Mem_rd, Mem_addr, Mem_data_in, Rdata0, Rdata1,
                 e_ack0, e_ack1, e_wr, e_rd, e_addr, e_din, e_rd0, e_rd1);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s got=%h want=%h t=%0t", name, got, want, $time);
    end
  endtask

  task automatic wait_ack(input int p, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge Clk);
      if ((p == 0 && Ack0 === 1'b1) || (p == 1 && Ack1 === 1'b1)) begin
        ok = 1'b1;
        break;
      end
    end
    n_checks++;
    if (!ok) begin
      n_err++;
      $display("FAIL ack_timeout port=%0d got=no_ack want=ack t=%0t", p, $time);
    end
  endtask

  bit exp_g [4];
  bit got_g [4];
  int gcnt, cnt, first;
  bit ok;

  initial begin
    mem_env[0] = 8'h11; mem_env[1] = 8'h00; mem_env[2] = 8'h00; mem_env[3] = 8'h33;
    mem_ref[0] = 8'h11; mem_ref[1] = 8'h00; mem_ref[2] = 8'h00; mem_ref[3] = 8'h33;
`ifdef MEM_ARB_RR_EN
    exp_g[0] = 0; exp_g[1] = 1; exp_g[2] = 0; exp_g[3] = 1;
`else
    exp_g[0] = 0; exp_g[1] = 0; exp_g[2] = 0; exp_g[3] = 0;
`endif

    // Reset state
    repeat (3) @(negedge Clk);
    chk_en = 1'b1;
    check("reset_outputs", 32'({Ack0, Ack1, Mem_wr, Mem_rd, Mem_addr, Mem_data_in, Rdata0, Rdata1}), 32'd0);
    Rst = 1'b0;

    // Port 0 writes 0xA5 to address 2
    Req0 = 1; Wr_en0 = 1; Addr0 = 2'd2; Wdata0 = 8'hA5;
    @(negedge Clk);
    check("wr_strobe", 32'(Mem_wr), 32'd1);
    check("wr_no_rd", 32'(Mem_rd), 32'd0);
    check("wr_addr", 32'(Mem_addr), 32'd2);
    check("wr_data", 32'(Mem_data_in), 32'hA5);
    check("wr_ack_early", 32'(Ack0), 32'd0);
    @(negedge Clk);
    check("wr_ack0", 32'(Ack0), 32'd1);
    check("wr_strobe_off", 32'(Mem_wr), 32'd0);
    Req0 = 0;
    @(negedge Clk);
    check("ack0_one_cycle", 32'(Ack0), 32'd0);

    // Port 1 reads address 2 back
    Req1 = 1; Wr_en1 = 0; Addr1 = 2'd2;
    @(negedge Clk);
    check("rd_strobe", 32'(Mem_rd), 32'd1);
    check("rd_no_wr", 32'(Mem_wr), 32'd0);
    @(negedge Clk);
    check("rd_ack1", 32'(Ack1), 32'd1);
    check("rd_rdata1", 32'(Rdata1), 32'hA5);
    check("rd_rdata0_untouched", 32'(Rdata0), 32'h00);
    Req1 = 0;
    @(negedge Clk);

    // Both ports request continuously
    Req0 = 1; Wr_en0 = 0; Addr0 = 2'd0;
    Req1 = 1; Wr_en1 = 0; Addr1 = 2'd3;
    gcnt = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge Clk);
      if (Ack0 === 1'b1 && gcnt < 4) begin got_g[gcnt] = 0; gcnt++; end
      if (Ack1 === 1'b1 && gcnt < 4) begin got_g[gcnt] = 1; gcnt++; end
    end
    Req0 = 0; Req1 = 0;
    check("arb_grant_count", 32'(gcnt), 32'd4);
    for (int k = 0; k < 4; k++) check($sformatf("arb_grant%0d", k), 32'(got_g[k]), 32'(exp_g[k]));
    @(negedge Clk);

    // Req0 dropped during ACCESS
    Req0 = 1; Wr_en0 = 0; Addr0 = 2'd3;
    @(negedge Clk);
    check("drop_rd_strobe", 32'(Mem_rd), 32'd1);
    Req0 = 0;
    @(negedge Clk);
    check("drop_ack0", 32'(Ack0), 32'd1);
    cnt = 0;
    repeat (4) begin
      @(negedge Clk);
      if (Ack0 || Ack1 || Mem_rd || Mem_wr) cnt++;
    end
    check("drop_no_regrant", 32'(cnt), 32'd0);

    // Reset during ACCESS of a write
    Req0 = 1; Wr_en0 = 1; Addr0 = 2'd1; Wdata0 = 8'h5A;
    @(negedge Clk);
    check("rst_wr_strobe", 32'(Mem_wr), 32'd1);
    Rst = 1; Req0 = 0;
    @(negedge Clk);
    check("rst_mid_outputs", 32'({Ack0, Ack1, Mem_wr, Mem_rd, Mem_addr, Mem_data_in, Rdata0, Rdata1}), 32'd0);
    Rst = 0;
    Req0 = 1; Wr_en0 = 0; Addr0 = 2'd1;
    Req1 = 1; Wr_en1 = 0; Addr1 = 2'd2;
    first = -1;
    for (int i = 0; i < 8 && first < 0; i++) begin
      @(negedge Clk);
      if (Ack0 === 1'b1) first = 0;
      else if (Ack1 === 1'b1) first = 1;
    end
    check("ptr_restart_first_grant", 32'(first), 32'd0);
    Req0 = 0;
    wait_ack(1, ok);
    Req1 = 0;
    @(negedge Clk);

    // Back-to-back reads of addresses 0 and 3 from port 0
    Req0 = 1; Wr_en0 = 0; Addr0 = 2'd0;
    wait_ack(0, ok);
    check("b2b_rdata0_first", 32'(Rdata0), 32'h11);
    Addr0 = 2'd3;
    @(negedge Clk);
    check("b2b_rdata0_held", 32'(Rdata0), 32'h11);
    wait_ack(0, ok);
    check("b2b_rdata0_second", 32'(Rdata0), 32'h33);
    Req0 = 0;
    repeat (2) @(negedge Clk);

    // Randomized traffic with occasional resets and early drops
    repeat (3000) begin
      @(negedge Clk);
      if (Req0 && Ack0) begin
        if ($urandom_range(3) != 0) Req0 = 0;
      end else if (!Req0) begin
        if ($urandom_range(2) == 0) begin
          Req0 = 1; Wr_en0 = 1'($urandom_range(1));
          Addr0 = N'($urandom_range(3)); Wdata0 = 8'($urandom);
        end
      end else if ($urandom_range(49) == 0) Req0 = 0;
      if (Req1 && Ack1) begin
        if ($urandom_range(3) != 0) Req1 = 0;
      end else if (!Req1) begin
        if ($urandom_range(2) == 0) begin
          Req1 = 1; Wr_en1 = 1'($urandom_range(1));
          Addr1 = N'($urandom_range(3)); Wdata1 = 8'($urandom);
        end
      end else if ($urandom_range(49) == 0) Req1 = 0;
      Rst = ($urandom_range(199) == 0);
    end
    Req0 = 0; Req1 = 0; Rst = 0;
    repeat (4) @(negedge Clk);
    for (int a = 0; a < 4; a++) check($sformatf("final_mem%0d", a), 32'(mem_env[a]), 32'(mem_ref[a]));

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/memory_arbiter.md
# memory_arbiter

Two-port arbiter and sequencer for the shared `Memory_Design` array. It accepts read and write requests from two independent requesters and serialises them onto the single memory port (`Data_in`, `addr`, `Wr`, `Rd`, `Data_out`). It drives single-cycle `Wr` and `Rd` strobes and returns read data with a one-cycle acknowledge. It sits between the bus-side masters and the memory array, and is the only block that drives the memory's control pins.

## Interface
Parameters:
- `N`, default 2: memory address width; must match the `N` of the connected `Memory_Design`.

Ports (one clock; reset is synchronous and active-high):
- `Clk`  in  1  system clock, rising-edge.
- `Rst`  in  1  synchronous, active-high reset.
- `Req0` / `Req1`  in  1  request from port 0 / port 1; held until `Ack` is seen.
- `Wr_en0` / `Wr_en1`  in  1  request type: 1 = write, 0 = read.
- `Addr0` / `Addr1`  in  N  request address.
- `Wdata0` / `Wdata1`  in  8  write data.
- `Ack0` / `Ack1`  out  1  one-cycle completion pulse.
- `Rdata0` / `Rdata1`  out  8  read data; valid with `Ack`, held until that port's next read completes.
- `Mem_addr`  out  N  memory address.
- `Mem_data_in`  out  8  memory write data.
- `Mem_wr` / `Mem_rd`  out  1  memory write / read strobe.
- `Mem_data_out`  in  8  memory read data; combinational from address.

## Operation
- FSM states and transitions:
  - IDLE → ACCESS when any `Req` is high.
  - ACCESS → DONE unconditionally.
  - DONE → IDLE unconditionally.
- IDLE:
  - Arbitrate among the ports whose `Req` is high.
  - Latch the winner's index, `Wr_en`, `Addr` and `Wdata` into internal registers.
- ACCESS:
  - `Mem_addr` and `Mem_data_in` carry the latched values.
  - Exactly one of `Mem_wr` / `Mem_rd` is high, according to the latched `Wr_en`.
  - For a read, `Mem_data_out` is captured into the winner's `Rdata` at the end of this cycle.
- DONE:
  - `Ack` of the latched port is high for exactly one cycle.
  - `Mem_wr` and `Mem_rd` are low.
- Arbitration:
  - A single requester always wins.
  - When both request, the port selected by the 1-bit priority pointer wins.
  - After each grant, the pointer moves to the non-granted port.
- Boundary conditions:
  - A `Req` that rises during ACCESS or DONE is not sampled until IDLE.
  - `Req` deasserted mid-transaction: the latched transaction still completes and `Ack` still pulses.
  - `Req` still high in IDLE after `Ack`: treated as a new request.
  - `Rdata` of a port is never modified by writes or by the other port's reads.
  - Address wrap-around does not apply; every `N`-bit address is passed through unchanged.
- Reset (any state, including mid-ACCESS):
  - Next state IDLE, priority pointer = port 0.
  - `Ack0`, `Ack1`, `Mem_wr`, `Mem_rd` = 0.
  - `Mem_addr` = 0, `Mem_data_in` = 0, `Rdata0` = `Rdata1` = 0.
  - An aborted write may or may not have reached the array; no `Ack` is issued for it.

## Timing
- All outputs are registered.
- Request sampled in IDLE at edge t:
  - `Mem_wr` / `Mem_rd` high during cycle t+1.
  - `Ack` and valid `Rdata` during cycle t+2.
  - FSM back in IDLE at t+3.
- Latency is 2 cycles from sample to `Ack`; peak throughput is 1 transaction per 3 cycles.
- `Mem_addr` and `Mem_data_in` are stable for the whole ACCESS cycle and hold their values until the next grant.
- The memory must resolve `Mem_data_out` within one clock period of `Mem_addr`.

## Configuration
- `MEM_ARB_RR_EN` defined: round-robin arbitration via the priority pointer, as described above.
- Not defined: fixed priority; port 0 always wins a simultaneous request and the pointer logic is omitted.
- Port 1 can starve only when the macro is not defined.

## Structure
- Package `mem_arb_pkg`:
  - State enum `mem_arb_state_t` {IDLE, ACCESS, DONE}.
  - Constant `MEM_ARB_PORTS = 2` and data width constant `MEM_DATA_W = 8`.
- Sub-module `rr_picker`:
  - Combinational 2-way grant from `Req` vector and pointer.
  - Contains the `MEM_ARB_RR_EN` selection.

## Test plan
- Reset, then port 0 writes 0xA5 to address 2 → `Mem_wr` high for one cycle with `Mem_addr`=2 and `Mem_data_in`=0xA5; `Ack0` two cycles after the sample.
- Port 1 reads address 2 after that write → `Mem_rd` one cycle; `Rdata1`=0xA5 with `Ack1`; `Rdata0` unchanged.
- Both ports request continuously with `MEM_ARB_RR_EN` defined → grants alternate 0,1,0,1 every 3 cycles. Without the macro → port 0 is granted every time.
- Port 0 drops `Req0` during ACCESS → transaction completes; `Ack0` pulses once; no new grant follows.
- Assert `Rst` during ACCESS of a write → next cycle all outputs are 0 and the FSM is in IDLE; no `Ack`; the pointer restarts at port 0.
- Back-to-back reads to addresses 0 and 3 from port 0 with memory preloaded 0x11 / 0x33 → `Rdata0`=0x11 then 0x33, each held until the next `Ack0`.
